// File: rtl/xloader_chip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | xloader_chip                                                               |
// | Boot streamer: reads BOOT_LEN bytes from SPI flash, sends them on a UART,  |
// | captures UART receive traffic and exports status on pads.                  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module xloader_chip #(
    parameter int          CLK_HZ         = 50000000,
    parameter int          BAUDRATE       = 25000000,
    parameter logic [23:0] BOOT_ADDR      = 24'h000000,
    parameter int          BOOT_LEN       = 16,
    parameter int          STARTUP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic        qspi_sck,
    inout  wire         qspi_dq0,
    inout  wire         qspi_dq1,
    inout  wire         qspi_dq2,
    inout  wire         qspi_dq3,
    output logic        qspi_cs0,
    output logic        qspi_cs1,
    output logic        qspi_cs2,
    output logic        qspi_cs3,
    output logic [31:0] pads
);

    localparam int          c_DIV      = CLK_HZ / BAUDRATE;
    localparam logic [15:0] c_DIV_M1   = 16'(c_DIV - 1);
    // First RX sample lands DIV/2 into data bit 0, counted from the edge that sees the start bit.
    localparam logic [15:0] c_RX_FIRST = 16'(c_DIV + c_DIV / 2 - 2);
    localparam logic [31:0] c_CMD      = {8'h03, BOOT_ADDR};
    localparam logic [31:0] c_STARTUP  = 32'(STARTUP_CYCLES);
    localparam logic [15:0] c_BOOT_LEN = 16'(BOOT_LEN);

    localparam logic [2:0] c_ST_STARTUP = 3'd0;
    localparam logic [2:0] c_ST_CMD     = 3'd1;
    localparam logic [2:0] c_ST_RDBYTE  = 3'd2;
    localparam logic [2:0] c_ST_TXWAIT  = 3'd3;
    localparam logic [2:0] c_ST_DONE    = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_startup_cnt;
    logic [31:0] r_cmd_sh;
    logic [7:0]  r_rd_byte;
    logic [4:0]  r_bit;
    logic        r_phase;
    logic        r_sck;
    logic        r_cs0;
    logic        r_dq0;
    logic        r_tx_started;
    logic [15:0] r_byte_cnt;
    logic [7:0]  r_tx_last;

    logic        r_tx;
    logic        r_tx_busy;
    logic [8:0]  r_tx_sh;
    logic [3:0]  r_tx_nbit;
    logic [15:0] r_tx_div;

    logic        r_rx_s1;
    logic        r_rx_s2;
    logic        r_rx_s3;
    logic        r_rx_active;
    logic [15:0] r_rx_div;
    logic [3:0]  r_rx_nbit;
    logic [7:0]  r_rx_sh;
    logic [7:0]  r_rx_last;
    logic [7:0]  r_rx_cnt;

    logic        w_tx_load;
    logic        w_busy;
    logic        w_done;

    assign w_tx_load = (r_state == c_ST_TXWAIT) && !r_tx_started;
    assign w_busy    = (r_state == c_ST_CMD) || (r_state == c_ST_RDBYTE) || (r_state == c_ST_TXWAIT);
    assign w_done    = (r_state == c_ST_DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state       <= c_ST_STARTUP;
            r_startup_cnt <= 32'd0;
            r_cmd_sh      <= 32'd0;
            r_rd_byte     <= 8'd0;
            r_bit         <= 5'd0;
            r_phase       <= 1'b0;
            r_sck         <= 1'b0;
            r_cs0         <= 1'b1;
            r_dq0         <= 1'b0;
            r_tx_started  <= 1'b0;
            r_byte_cnt    <= 16'd0;
            r_tx_last     <= 8'd0;
        end else begin
            case (r_state)
                c_ST_STARTUP: begin
                    if (r_startup_cnt == c_STARTUP) begin
                        r_state  <= c_ST_CMD;
                        r_cs0    <= 1'b0;
                        r_dq0    <= c_CMD[31];
                        r_cmd_sh <= {c_CMD[30:0], 1'b0};
                        r_bit    <= 5'd0;
                        r_phase  <= 1'b0;
                    end else begin
                        r_startup_cnt <= r_startup_cnt + 32'd1;
                    end
                end
                c_ST_CMD: begin
                    if (!r_phase) begin
                        r_sck   <= 1'b1;
                        r_phase <= 1'b1;
                    end else begin
                        // MOSI only moves on the edge that takes sck low.
                        r_sck    <= 1'b0;
                        r_phase  <= 1'b0;
                        r_dq0    <= r_cmd_sh[31];
                        r_cmd_sh <= {r_cmd_sh[30:0], 1'b0};
                        if (r_bit == 5'd31) begin
                            r_state <= c_ST_RDBYTE;
                            r_bit   <= 5'd0;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end
                end
                c_ST_RDBYTE: begin
                    if (!r_phase) begin
                        r_sck   <= 1'b1;
                        r_phase <= 1'b1;
                    end else begin
                        r_sck     <= 1'b0;
                        r_phase   <= 1'b0;
                        r_rd_byte <= {r_rd_byte[6:0], qspi_dq1};
                        if (r_bit == 5'd7) begin
                            r_state      <= c_ST_TXWAIT;
                            r_bit        <= 5'd0;
                            r_tx_started <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 5'd1;
                        end
                    end
                end
                c_ST_TXWAIT: begin
                    if (!r_tx_started) begin
                        r_tx_started <= 1'b1;
                        r_tx_last    <= r_rd_byte;
                    end else if (!r_tx_busy) begin
                        r_tx_started <= 1'b0;
                        r_byte_cnt   <= r_byte_cnt + 16'd1;
                        if (r_byte_cnt + 16'd1 == c_BOOT_LEN) begin
                            r_state <= c_ST_DONE;
                            r_cs0   <= 1'b1;
                        end else begin
                            r_state <= c_ST_RDBYTE;
                        end
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_STARTUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tx      <= 1'b1;
            r_tx_busy <= 1'b0;
            r_tx_sh   <= 9'd0;
            r_tx_nbit <= 4'd0;
            r_tx_div  <= 16'd0;
        end else if (w_tx_load) begin
            r_tx      <= 1'b0;
            r_tx_sh   <= {1'b1, r_rd_byte};
            r_tx_nbit <= 4'd9;
            r_tx_div  <= c_DIV_M1;
            r_tx_busy <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_div != 16'd0) begin
                r_tx_div <= r_tx_div - 16'd1;
            end else if (r_tx_nbit == 4'd0) begin
                r_tx_busy <= 1'b0;
            end else begin
                r_tx      <= r_tx_sh[0];
                r_tx_sh   <= {1'b0, r_tx_sh[8:1]};
                r_tx_nbit <= r_tx_nbit - 4'd1;
                r_tx_div  <= c_DIV_M1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rx_s1     <= 1'b1;
            r_rx_s2     <= 1'b1;
            r_rx_s3     <= 1'b1;
            r_rx_active <= 1'b0;
            r_rx_div    <= 16'd0;
            r_rx_nbit   <= 4'd0;
            r_rx_sh     <= 8'd0;
            r_rx_last   <= 8'd0;
            r_rx_cnt    <= 8'd0;
        end else begin
            r_rx_s1 <= uart_rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
            if (!r_rx_active) begin
                if (r_rx_s3 && !r_rx_s2) begin
                    r_rx_active <= 1'b1;
                    r_rx_div    <= c_RX_FIRST;
                    r_rx_nbit   <= 4'd0;
                end
            end else if (r_rx_div != 16'd0) begin
                r_rx_div <= r_rx_div - 16'd1;
            end else begin
                r_rx_div <= c_DIV_M1;
                if (r_rx_nbit != 4'd8) begin
                    r_rx_sh   <= {r_rx_s2, r_rx_sh[7:1]};
                    r_rx_nbit <= r_rx_nbit + 4'd1;
                end else begin
                    // A low stop bit is a framing error: drop the byte.
                    r_rx_active <= 1'b0;
                    if (r_rx_s2) begin
                        r_rx_last <= r_rx_sh;
                        r_rx_cnt  <= r_rx_cnt + 8'd1;
                    end
                end
            end
        end
    end

    assign uart_tx  = r_tx;
    assign qspi_sck = r_sck;
    assign qspi_cs0 = r_cs0;
    assign qspi_cs1 = 1'b1;
    assign qspi_cs2 = 1'b1;
    assign qspi_cs3 = 1'b1;
    assign qspi_dq0 = r_dq0;
    assign qspi_dq2 = 1'b1;
    assign qspi_dq3 = 1'b1;
    assign pads     = {w_done, w_busy, 6'd0, r_rx_cnt, r_tx_last, r_rx_last};

endmodule
`default_nettype wire

// File: tb/tb_xloader_chip.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_xloader_chip                                                            |
// | Board-level bench: UART loopback and a behavioural SPI read-only flash.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_xloader_chip;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    wire         uart_rx;
    wire         uart_tx;
    wire         qspi_sck;
    wire         qspi_dq0;
    wire         qspi_dq1;
    wire         qspi_dq2;
    wire         qspi_dq3;
    wire         qspi_cs0;
    wire         qspi_cs1;
    wire         qspi_cs2;
    wire         qspi_cs3;
    wire  [31:0] pads;

    int checks = 0;
    int failures = 0;
    int sck_rises = 0;
    int sck_base = 0;
    int mon_n = 0;
    int mon_base = 0;
    logic [7:0] mon_bytes [64];
    logic [7:0] mon_b;
    logic [7:0] mem [16];

    logic [31:0] fl_cmd = 32'd0;
    int          fl_bits = 0;
    int          fl_idx;
    logic [7:0]  fl_byte;
    logic        fl_dq1 = 1'b0;

    assign uart_rx  = uart_tx;
    assign qspi_dq1 = fl_dq1;

    xloader_chip dut (
        .clk      (clk),
        .resetn   (resetn),
        .uart_rx  (uart_rx),
        .uart_tx  (uart_tx),
        .qspi_sck (qspi_sck),
        .qspi_dq0 (qspi_dq0),
        .qspi_dq1 (qspi_dq1),
        .qspi_dq2 (qspi_dq2),
        .qspi_dq3 (qspi_dq3),
        .qspi_cs0 (qspi_cs0),
        .qspi_cs1 (qspi_cs1),
        .qspi_cs2 (qspi_cs2),
        .qspi_cs3 (qspi_cs3),
        .pads     (pads)
    );

    always #5 clk = ~clk;

    always @(posedge qspi_sck) sck_rises++;

    // Flash model: 32 command/address bits in on sck rise, data out on sck fall.
    always @(posedge qspi_sck or posedge qspi_cs0) begin
        if (qspi_cs0) begin
            fl_bits <= 0;
        end else begin
            if (fl_bits < 32) fl_cmd <= {fl_cmd[30:0], qspi_dq0};
            fl_bits <= fl_bits + 1;
        end
    end

    always @(negedge qspi_sck) begin
        if (qspi_cs0 === 1'b0 && fl_bits >= 32) begin
            fl_idx  = fl_bits - 32;
            fl_byte = mem[(fl_idx / 8) % 16];
            fl_dq1 <= fl_byte[3'(7 - (fl_idx % 8))];
        end
    end

    // UART frame decoder on uart_tx, sampling mid-cell on the falling clock.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn === 1'b1 && uart_tx === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (2) @(negedge clk);
                    mon_b[i] = uart_tx;
                end
                repeat (2) @(negedge clk);
                if (mon_n < 64) mon_bytes[mon_n] = mon_b;
                mon_n++;
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        checks++; if (qspi_cs0 !== 1'b1) begin failures++; $display("FAIL reset_cs0 got=%b exp=1", qspi_cs0); end
        checks++; if (qspi_sck !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", qspi_sck); end
        checks++; if (uart_tx !== 1'b1) begin failures++; $display("FAIL reset_uart_tx got=%b exp=1", uart_tx); end
        checks++; if (pads !== 32'h0) begin failures++; $display("FAIL reset_pads got=%h exp=00000000", pads); end
        checks++; if ({qspi_cs1, qspi_cs2, qspi_cs3} !== 3'b111) begin
            failures++; $display("FAIL reset_cs123 got=%b exp=111", {qspi_cs1, qspi_cs2, qspi_cs3});
        end
        checks++; if ({qspi_dq2, qspi_dq3} !== 2'b11) begin
            failures++; $display("FAIL reset_dq23 got=%b exp=11", {qspi_dq2, qspi_dq3});
        end
        checks++; if (qspi_dq0 !== 1'b0) begin failures++; $display("FAIL reset_dq0 got=%b exp=0", qspi_dq0); end
    endtask

    task automatic test_startup();
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 1100 && !seen; i++) begin
            @(posedge clk);
            #1;
            n++;
            if (qspi_cs0 === 1'b0) seen = 1;
        end
        sck_base = sck_rises;
        checks++; if (!seen || n != 1001) begin failures++; $display("FAIL startup_cs0_fall got_clock=%0d seen=%0d exp_clock=1001", n, seen); end
        checks++; if (qspi_sck !== 1'b0 || qspi_dq0 !== 1'b0) begin
            failures++; $display("FAIL startup_sck_dq0 got=%b%b exp=00", qspi_sck, qspi_dq0);
        end
        checks++; if (pads[30] !== 1'b1) begin failures++; $display("FAIL startup_busy got=%b exp=1", pads[30]); end
    endtask

    task automatic test_cmd();
        bit seen;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx === 1'b0) seen = 1;
        end
        checks++; if (!seen || (sck_rises - sck_base) != 40) begin
            failures++; $display("FAIL cmd_sck_pulses got=%0d seen=%0d exp=40", sck_rises - sck_base, seen);
        end
        checks++; if (fl_cmd !== 32'h03000000) begin failures++; $display("FAIL cmd_bits got=%h exp=03000000", fl_cmd); end
    endtask

    // Entered one step after the edge that drove the start bit.
    task automatic test_frame(input logic [9:0] exp_frame, input logic [7:0] exp_byte, input string name);
        logic [19:0] got;
        logic [19:0] exp;
        for (int j = 0; j < 20; j++) begin
            got[j] = uart_tx;
            exp[j] = exp_frame[j / 2];
            if (j < 19) begin
                @(posedge clk);
                #1;
            end
        end
        checks++; if (got !== exp) begin failures++; $display("FAIL %s_frame got=%h exp=%h", name, got, exp); end
        checks++; if (pads[15:8] !== exp_byte) begin failures++; $display("FAIL %s_tx_last got=%h exp=%h", name, pads[15:8], exp_byte); end
    endtask

    task automatic test_loopback_rx(input logic [7:0] exp_byte, input logic [7:0] exp_cnt);
        bit seen;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (pads[23:16] === exp_cnt) seen = 1;
        end
        checks++; if (pads[23:16] !== exp_cnt) begin failures++; $display("FAIL rx_count got=%0d exp=%0d", pads[23:16], exp_cnt); end
        checks++; if (pads[7:0] !== exp_byte) begin failures++; $display("FAIL rx_byte got=%h exp=%h", pads[7:0], exp_byte); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (uart_tx === 1'b0) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL b2b_start got=timeout exp=start_bit"); end
        test_frame(10'b1_0011_1100_0, 8'h3C, "byte2");
        test_loopback_rx(8'h3C, 8'd2);
    endtask

    task automatic test_done();
        bit seen;
        int s;
        seen = 0;
        for (int i = 0; i < 1500 && !seen; i++) begin
            @(negedge clk);
            if (pads[31] === 1'b1) seen = 1;
        end
        repeat (4) @(negedge clk);
        checks++; if (pads[31] !== 1'b1) begin failures++; $display("FAIL done_flag got=%b exp=1", pads[31]); end
        checks++; if (pads[30] !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", pads[30]); end
        checks++; if (qspi_cs0 !== 1'b1) begin failures++; $display("FAIL done_cs0 got=%b exp=1", qspi_cs0); end
        checks++; if (pads[23:16] !== 8'd16) begin failures++; $display("FAIL done_rx_count got=%0d exp=16", pads[23:16]); end
        checks++; if (pads[15:0] !== 16'h0101) begin failures++; $display("FAIL done_last_bytes got=%h exp=0101", pads[15:0]); end
        checks++; if (mon_n - mon_base != 16) begin failures++; $display("FAIL done_frames got=%0d exp=16", mon_n - mon_base); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (mon_base + i >= mon_n || mon_bytes[mon_base + i] !== mem[i]) begin
                failures++; $display("FAIL stream_byte%0d got=%h exp=%h", i, mon_bytes[(mon_base + i) % 64], mem[i]);
            end
        end
        s = sck_rises;
        repeat (1000) @(posedge clk);
        @(negedge clk);
        checks++; if (sck_rises != s || qspi_sck !== 1'b0) begin
            failures++; $display("FAIL done_sck_idle got=%0d exp=0", sck_rises - s);
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        mon_base = mon_n;
        test_startup();
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if (mon_n - mon_base >= 2) seen = 1;
        end
        checks++; if (!seen) begin failures++; $display("FAIL mid_two_bytes got=%0d exp=2", mon_n - mon_base); end
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (qspi_sck === 1'b1) seen = 1;
        end
        checks++; if (!seen || pads[30] !== 1'b1) begin failures++; $display("FAIL mid_in_rdbyte got=%b exp=1", pads[30]); end
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (qspi_cs0 !== 1'b1 || qspi_sck !== 1'b0) begin
            failures++; $display("FAIL mid_reset_spi got=%b%b exp=10", qspi_cs0, qspi_sck);
        end
        checks++; if (uart_tx !== 1'b1 || qspi_dq0 !== 1'b0) begin
            failures++; $display("FAIL mid_reset_tx_dq0 got=%b%b exp=10", uart_tx, qspi_dq0);
        end
        checks++; if (pads !== 32'h0) begin failures++; $display("FAIL mid_reset_pads got=%h exp=00000000", pads); end
        repeat (4) @(posedge clk);
        test_startup();
        test_cmd();
        test_frame(10'b1_1010_0101_0, 8'hA5, "restart");
    endtask

    initial begin
        mem[0]  = 8'hA5; mem[1]  = 8'h3C; mem[2]  = 8'h5A; mem[3]  = 8'hC3;
        mem[4]  = 8'h0F; mem[5]  = 8'hF0; mem[6]  = 8'h81; mem[7]  = 8'h7E;
        mem[8]  = 8'h12; mem[9]  = 8'h34; mem[10] = 8'h56; mem[11] = 8'h78;
        mem[12] = 8'h9A; mem[13] = 8'hBC; mem[14] = 8'hDE; mem[15] = 8'h01;
        test_reset();
        mon_base = mon_n;
        test_startup();
        test_cmd();
        test_frame(10'b1_1010_0101_0, 8'hA5, "byte1");
        test_loopback_rx(8'hA5, 8'd1);
        test_back_to_back();
        test_done();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
